// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and state encoding
// for the UART receive path.
package uart_pkg;

    localparam int CLK_HZ      = 12_000_000;
    localparam int BAUD        = 115200;
    localparam int CPB_DEFAULT = 104;
    localparam int DATA_BITS   = 8;
    localparam int CNT_W       = 11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: receiver output bundle (byte, strobes,
// busy) from uart_rx (master) to its consumer (slave).
interface uart_rx_if import uart_pkg::*; ();

    logic [DATA_BITS-1:0] o_data;
    logic                 o_valid;
    logic                 o_frame_err;
    logic                 o_busy;

    modport master (
        output o_data,
        output o_valid,
        output o_frame_err,
        output o_busy
    );

    modport slave (
        input o_data,
        input o_valid,
        input o_frame_err,
        input o_busy
    );

endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-FF synchronizer for an asynchronous
// input; flops reset to 1 to match an idle-high line.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic meta_q;
    logic sync_q;

    // Two-stage resynchronisation into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= i_async;
            sync_q <= meta_q;
        end
    end

    assign o_sync = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver, LSB first, centre sampling,
// one-cycle valid / framing-error strobes.
module uart_rx import uart_pkg::*; #(
    parameter int CPB = CPB_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_Rx,
    uart_rx_if.master  rx_if
);

    localparam int HALF = CPB / 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);

    logic                 rx_s;
    rx_state_e            state_q;
    logic [CNT_W-1:0]     clk_cnt_q;
    logic [2:0]           bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 busy_q;
    logic                 armed_q;
    logic                 cnt_done;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (i_Rx),
        .o_sync  (rx_s)
    );

    assign shift_d  = {rx_s, shift_q[DATA_BITS-1:1]};
    assign cnt_done = (clk_cnt_q == CNT_LAST);

    // Frame FSM; armed_q blocks a start until the line
    // has been seen high after reset (mid-frame reset).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            armed_q <= armed_q | rx_s;
            case (state_q)
                IDLE: begin
                    if (armed_q && !rx_s) begin
                        state_q   <= START;
                        clk_cnt_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                START: begin
                    if (clk_cnt_q == CNT_MID) begin
                        clk_cnt_q <= '0;
                        if (!rx_s) begin
                            state_q   <= DATA;
                            bit_idx_q <= '0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_done) begin
                        shift_q   <= shift_d;
                        clk_cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt_done) begin
                        clk_cnt_q <= '0;
                        if (rx_s) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= BRK;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                BRK: begin
                    if (rx_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_if.o_data      = data_q;
    assign rx_if.o_valid     = valid_q;
    assign rx_if.o_frame_err = ferr_q;
    assign rx_if.o_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx, driving the
// serial line with a behavioural 8N1 transmitter.
module tb_uart_rx;

    localparam int CPB  = 104;
    localparam int HALF = CPB / 2;
    localparam int LAT  = 2 + HALF + 9 * CPB + 1;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        int         exp_valid;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    logic clk;
    logic rst;
    logic i_Rx;

    uart_rx_if rx_if ();

    uart_rx #(.CPB(CPB)) dut (
        .clk   (clk),
        .rst   (rst),
        .i_Rx  (i_Rx),
        .rx_if (rx_if)
    );

    int checks;
    int errors;
    int cyc;
    int start_cyc;
    int ferr_n;
    int busy_cnt;
    int viol;
    logic prev_strobe;
    logic [7:0] vq_data[$];
    int         vq_cyc[$];
    vec_t vecs[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter: value equals index of last posedge.
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (rx_if.o_valid) begin
            vq_data.push_back(rx_if.o_data);
            vq_cyc.push_back(cyc);
        end
        if (rx_if.o_frame_err) ferr_n = ferr_n + 1;
        if (rx_if.o_busy) busy_cnt = busy_cnt + 1;
        if (rx_if.o_valid && rx_if.o_frame_err) viol = viol + 1;
        if ((rx_if.o_valid || rx_if.o_frame_err) && prev_strobe)
            viol = viol + 1;
        prev_strobe = rx_if.o_valid | rx_if.o_frame_err;
    end

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int n);
        i_Rx = b;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        start_cyc = cyc;
        send_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) send_bit(d[i], CPB);
        send_bit(stop_b, CPB);
    endtask

    initial begin
        int v0;
        int f0;
        int b0;
        int st[3];
        logic [7:0] b2b[3];

        checks = 0;
        errors = 0;
        cyc = 0;
        ferr_n = 0;
        busy_cnt = 0;
        viol = 0;
        prev_strobe = 1'b0;
        start_cyc = 0;

        vecs[0] = '{8'h44, 1'b1, 20,      1, 8'h44, 0};
        vecs[1] = '{8'h5A, 1'b1, 20,      1, 8'h5A, 0};
        vecs[2] = '{8'hA5, 1'b0, 2 * CPB, 0, 8'h5A, 1};
        vecs[3] = '{8'h3C, 1'b1, 20,      1, 8'h3C, 0};
        b2b[0] = 8'h00;
        b2b[1] = 8'hFF;
        b2b[2] = 8'h55;

        rst = 1'b1;
        i_Rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("reset_data", int'(rx_if.o_data), 0);
        check("reset_valid", int'(rx_if.o_valid), 0);
        check("reset_ferr", int'(rx_if.o_frame_err), 0);
        check("reset_busy", int'(rx_if.o_busy), 0);
        rst = 1'b0;
        send_bit(1'b1, 10);

        for (int k = 0; k < 4; k++) begin
            v0 = vq_data.size();
            f0 = ferr_n;
            send_frame(vecs[k].data, vecs[k].stop);
            send_bit(1'b1, vecs[k].gap);
            check($sformatf("vec%0d_valid", k),
                  vq_data.size() - v0, vecs[k].exp_valid);
            check($sformatf("vec%0d_ferr", k),
                  ferr_n - f0, vecs[k].exp_ferr);
            check($sformatf("vec%0d_data", k),
                  int'(rx_if.o_data), int'(vecs[k].exp_data));
        end

        // Glitch shorter than half a bit.
        v0 = vq_data.size();
        f0 = ferr_n;
        b0 = busy_cnt;
        send_bit(1'b0, 20);
        send_bit(1'b1, 200);
        check("glitch_busy_cycles", busy_cnt - b0, HALF);
        check("glitch_valid", vq_data.size() - v0, 0);
        check("glitch_ferr", ferr_n - f0, 0);

        // Break: line low for three frame times.
        v0 = vq_data.size();
        f0 = ferr_n;
        send_bit(1'b0, 30 * CPB);
        check("break_busy_low", int'(rx_if.o_busy), 1);
        check("break_ferr", ferr_n - f0, 1);
        check("break_valid", vq_data.size() - v0, 0);
        send_bit(1'b1, 10);
        check("break_idle", int'(rx_if.o_busy), 0);
        send_frame(8'h81, 1'b1);
        send_bit(1'b1, 20);
        check("break_after_valid", vq_data.size() - v0, 1);
        check("break_after_data", int'(rx_if.o_data), 8'h81);

        // Reset pulse during data bit 4 of 0xF0.
        v0 = vq_data.size();
        f0 = ferr_n;
        send_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) send_bit(1'b0, CPB);
        send_bit(1'b1, CPB / 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rstmid_data", int'(rx_if.o_data), 0);
        check("rstmid_busy", int'(rx_if.o_busy), 0);
        send_bit(1'b1, CPB - CPB / 2 - 1);
        for (int i = 5; i < 8; i++) send_bit(1'b1, CPB);
        send_bit(1'b1, CPB);
        send_bit(1'b1, 2 * CPB);
        check("rstmid_no_valid", vq_data.size() - v0, 0);
        check("rstmid_no_ferr", ferr_n - f0, 0);
        send_frame(8'h0F, 1'b1);
        send_bit(1'b1, 20);
        check("rstmid_next_valid", vq_data.size() - v0, 1);
        check("rstmid_next_data", int'(rx_if.o_data), 8'h0F);

        // Back-to-back frames with no idle gap.
        v0 = vq_data.size();
        f0 = ferr_n;
        for (int i = 0; i < 3; i++) begin
            send_frame(b2b[i], 1'b1);
            st[i] = start_cyc;
        end
        send_bit(1'b1, 2 * CPB);
        check("b2b_count", vq_data.size() - v0, 3);
        check("b2b_ferr", ferr_n - f0, 0);
        if (vq_data.size() - v0 == 3) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("b2b%0d_data", i),
                      int'(vq_data[v0 + i]), int'(b2b[i]));
                check($sformatf("b2b%0d_latency", i),
                      vq_cyc[v0 + i] - st[i], LAT);
            end
        end

        check("strobe_exclusive", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver: 8N1 UART, LSB first, idle-high line.
- Downstream consumer of the UART transmitter's serial output. Clock is the 12 MHz board clock; default rate is 115200 baud.
- Recovers each byte by sampling at the bit centre.
- Presents the byte with a one-cycle valid strobe. Flags framing errors.

Parameters:
- CPB, 104, clocks per bit (12 MHz / 115200). Legal range 8 to 2047.
- HALF, CPB/2, clocks from the detected start edge to the start-bit centre. Derived; not overridden.

Ports:
- clk  input  1  system clock, 12 MHz.
- rst  input  1  synchronous reset, active high.
- i_Rx  input  1  asynchronous serial line, idle high.
- o_data  output  8  last correctly received byte. Holds its value until the next good frame.
- o_valid  output  1  one-cycle high pulse; o_data is new.
- o_frame_err  output  1  one-cycle high pulse; stop bit was sampled low.
- o_busy  output  1  high while a frame is in progress (any state other than IDLE).

Behaviour:
- Synchronizer: 2-FF on i_Rx, both flops reset to 1. All logic uses the synchronized line rx_s. Input-to-rx_s latency is 2 clocks.
- Reset (rst high at clk edge): state=IDLE, counters=0, shift register=0.
  - Output reset values: o_data=0, o_valid=0, o_frame_err=0, o_busy=0.
  - Reset mid-frame aborts the frame with no strobe. The receiver rearms only after rx_s is seen high.
- Counters:
  - clk_cnt: 11 bits, counts 0..CPB-1.
  - bit_idx: 3 bits, counts 0..7.
- State machine:
  - IDLE: rx_s=0 → START, clk_cnt=0. Otherwise stay.
  - START: when clk_cnt==HALF-1, sample rx_s.
    - Sample 0 → DATA, clk_cnt=0, bit_idx=0.
    - Sample 1 → false start, back to IDLE with no strobes.
  - DATA: when clk_cnt==CPB-1, shift rx_s into bit 7 of the shift register (right shift, so LSB first) and set clk_cnt=0.
    - bit_idx==7 → STOP.
    - Otherwise bit_idx+1.
  - STOP: when clk_cnt==CPB-1, sample rx_s.
    - Sample 1: o_data←shift register; o_valid=1 for the next cycle; go to IDLE.
    - Sample 0: o_frame_err=1 for the next cycle; o_data unchanged; go to BRK.
  - BRK: wait for rx_s=1, then go to IDLE. A continuously low line yields exactly one o_frame_err.
- Timing:
  - Start-bit centre sample: HALF clocks after the first rx_s=0 cycle.
  - Each later sample: exactly CPB clocks after the previous one.
  - o_valid rises HALF + 9·CPB + 1 clocks after the first rx_s=0 cycle.
- o_valid and o_frame_err are mutually exclusive and never high for two consecutive cycles.
- A new start edge is accepted in the first IDLE cycle after STOP. Back-to-back frames from a transmitter with a 1-bit stop are received with no loss.
- Minimum frame spacing tolerated: stop bit plus 0 idle clocks.
- Baud mismatch up to ±3% is tolerated, because sampling is at the bit centre.

Decomposition:
- Package uart_pkg:
  - constants CLK_HZ=12_000_000, BAUD=115200, CPB_DEFAULT=104, DATA_BITS=8;
  - state encoding IDLE/START/DATA/STOP/BRK (3 bits).
- Sub-module uart_rx_sync: 2-FF synchronizer.
  - Ports clk, rst, i_async, o_sync.
  - Reset value 1.
  - Shared with any future asynchronous inputs.

Test Plan:
- Loopback: UART_Tx (CPB 104) → uart_rx (CPB 104) sends 0x44, then 0x5A → o_valid pulses twice, o_data=0x44 then 0x5A, o_frame_err never high.
- Glitch: i_Rx low for 20 clocks, then high → o_busy high for about 52 clocks, then IDLE; no o_valid, no o_frame_err.
- Framing error: drive 0xA5 with the stop bit low, then the line high → one o_frame_err pulse; o_data keeps its previous value; a following good 0x3C frame is received correctly.
- Break: i_Rx held low for 3 frame times → exactly one o_frame_err; state BRK until the line returns high; then 0x81 is received correctly.
- Reset mid-frame: assert rst for 1 clock during data bit 4 of 0xF0 → no strobe; outputs at reset values; the next 0x0F frame is received correctly.
- Back-to-back and latency: 0x00, 0xFF, 0x55 sent with zero idle gap → three o_valid pulses with correct data; each o_valid rises at HALF + 9·CPB + 1 clocks after the corresponding rx_s falling edge.
